// File: rtl/invaders_pkg.sv
// Shared types and widths for the invaders playfield and its bullet generator.
package invaders_pkg;

  localparam int BULLET_X_W = 5;
  localparam int BULLET_Y_W = 4;

  // Row driven while no bullet is in flight; invaders never reports a hit here.
  localparam int unsigned PARK_Y_DEFAULT = 15;

  typedef enum logic [1:0] {
    IDLE,
    FLYING,
    RETIRE
  } bullet_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/bullet_ctrl_if.sv
// Bullet generator <-> game top level signal bundle.
// o_hit_count exists only when BULLET_HIT_COUNT_EN is defined.
interface bullet_ctrl_if;
  import invaders_pkg::*;

  logic                  i_fire;
  logic [BULLET_X_W-1:0] i_cannon_x;
  logic                  i_hit;
  logic [BULLET_X_W-1:0] o_bullet_x;
  logic [BULLET_Y_W-1:0] o_bullet_y;
  logic                  o_active;
`ifdef BULLET_HIT_COUNT_EN
  logic [7:0]            o_hit_count;

  modport master (
    output i_fire, i_cannon_x, i_hit,
    input  o_bullet_x, o_bullet_y, o_active, o_hit_count
  );
  modport slave (
    input  i_fire, i_cannon_x, i_hit,
    output o_bullet_x, o_bullet_y, o_active, o_hit_count
  );
`else
  modport master (
    output i_fire, i_cannon_x, i_hit,
    input  o_bullet_x, o_bullet_y, o_active
  );
  modport slave (
    input  i_fire, i_cannon_x, i_hit,
    output o_bullet_x, o_bullet_y, o_active
  );
`endif

endinterface

// File: rtl/bullet_step_timer.sv
// Free-running divider producing a one-cycle tick every DIV enabled cycles.
module bullet_step_timer #(
  parameter int unsigned DIV = 1800000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  localparam logic [31:0] LAST = 32'(DIV - 1);

  logic [31:0] count;

  assign o_tick = i_enable && (count == LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count <= 32'd0;
    end else if (i_clear) begin
      count <= 32'd0;
    end else if (i_enable) begin
      if (count == LAST) count <= 32'd0;
      else               count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/bullet_ctrl.sv
// Player bullet generator: launches on fire edge, climbs one row per step tick.
// Optional hit counter enabled by defining BULLET_HIT_COUNT_EN.
module bullet_ctrl
  import invaders_pkg::*;
#(
  parameter int unsigned STEP_DIV = 1800000,
  parameter int unsigned START_Y  = 14,
  parameter int unsigned PARK_Y   = PARK_Y_DEFAULT
) (
  input logic          i_clk_36MHz,
  input logic          i_reset,
  bullet_ctrl_if.slave bus
);

  localparam logic [BULLET_Y_W-1:0] START_ROW = BULLET_Y_W'(START_Y);
  localparam logic [BULLET_Y_W-1:0] PARK_ROW  = BULLET_Y_W'(PARK_Y);

  bullet_state_t         state;
  logic                  fire_q;
  logic                  fire_edge;
  logic                  step_tick;
  logic                  timer_clear;
  logic                  timer_enable;
  logic [BULLET_X_W-1:0] bullet_x;
  logic [BULLET_Y_W-1:0] bullet_y;
  logic                  active;
`ifdef BULLET_HIT_COUNT_EN
  logic [7:0]            hit_count;
`endif

  assign fire_edge    = bus.i_fire & ~fire_q;
  // Timer sits at zero outside FLYING, so every launch starts a full step period.
  assign timer_enable = (state == FLYING);
  assign timer_clear  = (state != FLYING);

  bullet_step_timer #(
    .DIV(STEP_DIV)
  ) u_step_timer (
    .i_clk    (i_clk_36MHz),
    .i_reset  (i_reset),
    .i_clear  (timer_clear),
    .i_enable (timer_enable),
    .o_tick   (step_tick)
  );

  always_ff @(posedge i_clk_36MHz or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      fire_q   <= 1'b0;
      bullet_x <= '0;
      bullet_y <= PARK_ROW;
      active   <= 1'b0;
`ifdef BULLET_HIT_COUNT_EN
      hit_count <= 8'd0;
`endif
    end else begin
      fire_q <= bus.i_fire;
      case (state)
        IDLE: begin
          if (fire_edge) begin
            state    <= FLYING;
            bullet_x <= bus.i_cannon_x;
            bullet_y <= START_ROW;
            active   <= 1'b1;
          end
        end
        FLYING: begin
          // A hit outranks a coincident tick, so the row is never decremented then.
          if (bus.i_hit) begin
            state    <= RETIRE;
            bullet_x <= '0;
            bullet_y <= PARK_ROW;
            active   <= 1'b0;
`ifdef BULLET_HIT_COUNT_EN
            hit_count <= sat_inc8(hit_count);
`endif
          end else if (step_tick) begin
            if (bullet_y == '0) begin
              state    <= RETIRE;
              bullet_x <= '0;
              bullet_y <= PARK_ROW;
              active   <= 1'b0;
            end else begin
              bullet_y <= bullet_y - 1'b1;
            end
          end
        end
        RETIRE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          bullet_x <= '0;
          bullet_y <= PARK_ROW;
          active   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_bullet_x = bullet_x;
  assign bus.o_bullet_y = bullet_y;
  assign bus.o_active   = active;
`ifdef BULLET_HIT_COUNT_EN
  assign bus.o_hit_count = hit_count;
`endif

endmodule

// File: tb/tb_bullet_ctrl.sv
// Scoreboard bench for bullet_ctrl with STEP_DIV=4, START_Y=14, PARK_Y=15.
// Hit-count checks are active when BULLET_HIT_COUNT_EN is defined.
module tb_bullet_ctrl;

  typedef struct {
    int         cyc;
    logic [4:0] x;
    logic [3:0] y;
    logic       act;
    logic [7:0] hc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  logic [7:0] hc_exp = 8'd0;
  exp_t sb[$];

  bullet_ctrl_if bus();

  bullet_ctrl #(
    .STEP_DIV (4),
    .START_Y  (14),
    .PARK_Y   (15)
  ) dut (
    .i_clk_36MHz (clock),
    .i_reset     (reset),
    .bus         (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] sample_hc();
`ifdef BULLET_HIT_COUNT_EN
    return bus.o_hit_count;
`else
    return 8'd0;
`endif
  endfunction

  task automatic push(input int c, input logic [4:0] x, input logic [3:0] y,
                      input logic act, input logic [7:0] hc);
    exp_t e;
    e.cyc = c;
    e.x   = x;
    e.y   = y;
    e.act = act;
`ifdef BULLET_HIT_COUNT_EN
    e.hc  = hc;
`else
    e.hc  = 8'd0;
`endif
    sb.push_back(e);
  endtask

  // Launch at cycle 'launch', then one row up every 4 cycles for 'steps' steps.
  task automatic push_flight(input int launch, input logic [4:0] x, input int steps,
                             input logic [7:0] hc);
    push(launch, x, 4'd14, 1'b1, hc);
    for (int s = 1; s <= steps; s++)
      push(launch + 4 * s, x, 4'(14 - s), 1'b1, hc);
  endtask

  task automatic wait_cycle(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic check_output(input string name, input logic [4:0] x,
                              input logic [3:0] y, input logic act);
    n_checks++;
    if (bus.o_bullet_x !== x || bus.o_bullet_y !== y || bus.o_active !== act) begin
      n_fail++;
      $display("[TB] FAIL %s: got x=%0d y=%0d act=%0b, expected x=%0d y=%0d act=%0b",
               name, bus.o_bullet_x, bus.o_bullet_y, bus.o_active, x, y, act);
    end
  endtask

  // Monitor: every observable output change must match the next scoreboard entry.
  initial begin
    logic [4:0] px;
    logic [3:0] py;
    logic       pa;
    logic [7:0] ph;
    exp_t       e;
    px = 5'd0; py = 4'd15; pa = 1'b0; ph = 8'd0;
    forever begin
      @(negedge clock);
      if (mon_en && (bus.o_bullet_x !== px || bus.o_bullet_y !== py ||
                     bus.o_active !== pa || sample_hc() !== ph)) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_change: cycle %0d got x=%0d y=%0d act=%0b hc=%0d, expected no change",
                   cyc, bus.o_bullet_x, bus.o_bullet_y, bus.o_active, sample_hc());
        end else begin
          e = sb.pop_front();
          n_checks++;
          if (bus.o_bullet_x !== e.x || bus.o_bullet_y !== e.y ||
              bus.o_active !== e.act || sample_hc() !== e.hc) begin
            n_fail++;
            $display("[TB] FAIL output_value: cycle %0d got x=%0d y=%0d act=%0b hc=%0d, expected x=%0d y=%0d act=%0b hc=%0d",
                     cyc, bus.o_bullet_x, bus.o_bullet_y, bus.o_active, sample_hc(),
                     e.x, e.y, e.act, e.hc);
          end
          n_checks++;
          if (cyc != e.cyc) begin
            n_fail++;
            $display("[TB] FAIL output_timing: change seen at cycle %0d, expected cycle %0d",
                     cyc, e.cyc);
          end
        end
        px = bus.o_bullet_x;
        py = bus.o_bullet_y;
        pa = bus.o_active;
        ph = sample_hc();
      end
    end
  end

  task automatic apply_stimulus();
    int l1, l2, l3, l4, l5;

    // Reset and idle
    bus.i_fire = 1'b0;
    bus.i_cannon_x = 5'd0;
    bus.i_hit = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_output("reset_state", 5'd0, 4'd15, 1'b0);
    n_checks++;
    if (sample_hc() !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_hit_count: got %0d, expected 0", sample_hc());
    end
    mon_en = 1'b1;
    repeat (10) @(negedge clock);
    check_output("idle_parked", 5'd0, 4'd15, 1'b0);

    // Full flight from column 9: 14 steps, retire by leaving the field
    bus.i_cannon_x = 5'd9;
    bus.i_fire = 1'b1;
    l1 = cyc + 1;
    push_flight(l1, 5'd9, 14, hc_exp);
    push(l1 + 60, 5'd0, 4'd15, 1'b0, hc_exp);
    wait_cycle(l1);
    bus.i_fire = 1'b0;
    wait_cycle(l1 + 64);

    // Hit at row 10, then relaunch two cycles later from column 3
    bus.i_fire = 1'b1;
    l1 = cyc + 1;
    push_flight(l1, 5'd9, 4, hc_exp);
    hc_exp = hc_exp + 8'd1;
    push(l1 + 18, 5'd0, 4'd15, 1'b0, hc_exp);
    wait_cycle(l1);
    bus.i_fire = 1'b0;
    wait_cycle(l1 + 17);
    bus.i_hit = 1'b1;
    wait_cycle(l1 + 18);
    bus.i_hit = 1'b0;
    wait_cycle(l1 + 19);
    bus.i_cannon_x = 5'd3;
    bus.i_fire = 1'b1;
    l2 = l1 + 20;
    push_flight(l2, 5'd3, 9, hc_exp);
    wait_cycle(l2);
    bus.i_fire = 1'b0;

    // Hit coincident with the tick at row 5: no decrement to 4
    hc_exp = hc_exp + 8'd1;
    push(l2 + 40, 5'd0, 4'd15, 1'b0, hc_exp);
    wait_cycle(l2 + 39);
    bus.i_hit = 1'b1;
    wait_cycle(l2 + 40);
    bus.i_hit = 1'b0;
    wait_cycle(l2 + 45);

    // Fire held 100 cycles with cannon moving mid-flight: one launch only
    bus.i_cannon_x = 5'd20;
    bus.i_fire = 1'b1;
    l3 = cyc + 1;
    push_flight(l3, 5'd20, 14, hc_exp);
    push(l3 + 60, 5'd0, 4'd15, 1'b0, hc_exp);
    wait_cycle(l3 + 10);
    bus.i_cannon_x = 5'd7;
    wait_cycle(l3 + 100);
    bus.i_fire = 1'b0;

    // New launch; a second press during flight is dropped
    wait_cycle(l3 + 102);
    bus.i_fire = 1'b1;
    l4 = cyc + 1;
    push_flight(l4, 5'd7, 7, hc_exp);
    wait_cycle(l4);
    bus.i_fire = 1'b0;
    wait_cycle(l4 + 5);
    bus.i_fire = 1'b1;
    wait_cycle(l4 + 6);
    bus.i_fire = 1'b0;

    // Asynchronous reset at row 7 clears everything including the hit count
    wait_cycle(l4 + 29);
    hc_exp = 8'd0;
    push(l4 + 30, 5'd0, 4'd15, 1'b0, hc_exp);
    #2;
    reset = 1'b1;
    #1;
    check_output("async_reset_park", 5'd0, 4'd15, 1'b0);
    wait_cycle(l4 + 32);
    reset = 1'b0;

    // Fresh launch after reset release
    wait_cycle(l4 + 34);
    bus.i_cannon_x = 5'd11;
    bus.i_fire = 1'b1;
    l5 = cyc + 1;
    push_flight(l5, 5'd11, 1, hc_exp);
    wait_cycle(l5);
    bus.i_fire = 1'b0;
    wait_cycle(l5 + 6);
  endtask

  initial begin
    apply_stimulus();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: %0d expected changes never observed, required 0",
               sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bullet_ctrl.md
# bullet_ctrl

Player-side bullet generator that drives the `i_bullet_x`/`i_bullet_y` inputs of `invaders` and consumes its `o_hit` output. On a fire request it launches a single bullet from the cannon column and advances it one row upward per step tick. It retires the bullet on a hit or when it leaves the top of the field. It sits beside `invaders` under the game top level, in the same 36 MHz domain.

## Interface
- `STEP_DIV`, default 1800000: clock cycles per bullet row step (20 rows/s at 36 MHz); legal range ≥ 2.
- `START_Y`, default 14: row the bullet occupies on the cycle after launch.
- `PARK_Y`, default 15: row driven while no bullet is in flight; `invaders` never reports a hit at this row.

Ports:
- `i_clk_36MHz` input 1: system clock.
- `i_reset` input 1: asynchronous, active-high reset.
- `i_fire` input 1: fire button level, synchronous to the clock; launch on rising edge.
- `i_cannon_x` input 5: current cannon column.
- `i_hit` input 1: registered hit flag from `invaders.o_hit`.
- `o_bullet_x` output 5: bullet column, to `invaders.i_bullet_x`.
- `o_bullet_y` output 4: bullet row, to `invaders.i_bullet_y`; 0 is the top row.
- `o_active` output 1: bullet in flight.
- `o_hit_count` output 8: present only with `BULLET_HIT_COUNT_EN`.

## Operation
- States:
  - IDLE: outputs parked (x=0, y=`PARK_Y`, `o_active`=0).
  - FLYING: bullet in flight.
  - RETIRE: one cycle, outputs parked.
- Fire edge: `fire_edge = i_fire & ~fire_q`. `fire_q` is registered every cycle in all states.
- IDLE → FLYING on `fire_edge`:
  - latch x = `i_cannon_x` and y = `START_Y`;
  - synchronously clear the step timer.
- Cannon movement after launch does not affect `o_bullet_x`.
- FLYING, in priority order:
  1. `i_hit`=1: go to RETIRE; count the hit. The tick is ignored that cycle.
  2. Step tick with y==0: go to RETIRE (bullet left the field).
  3. Step tick: y ← y−1; x holds.
- RETIRE → IDLE unconditionally.
- Ignored inputs:
  - `fire_edge` in FLYING or RETIRE is dropped, not queued.
  - `i_hit` in IDLE or RETIRE is ignored.
- Step timer:
  - counts 0..`STEP_DIV`−1 and pulses a tick when count == `STEP_DIV`−1, then wraps to 0;
  - held at 0 whenever the state is not FLYING.
- Reset values (asynchronous):
  - state IDLE, `fire_q`=0;
  - `o_bullet_x`=0, `o_bullet_y`=`PARK_Y`, `o_active`=0;
  - timer count 0, `o_hit_count`=0.
- Reset asserted mid-flight kills the bullet immediately; no RETIRE cycle.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Launch: `fire_edge` sampled at edge N → `o_active`=1, x/y valid after edge N.
- First step: `STEP_DIV` cycles after launch; each subsequent step every `STEP_DIV` cycles.
- Full flight from `START_Y` with no hit: `(START_Y+1)·STEP_DIV` cycles, then RETIRE (1 cycle), then IDLE.
- Hit: `i_hit` sampled at edge N → parked outputs after N, IDLE after N+1. A new `fire_edge` is accepted from edge N+2 onward.
- Hit and tick in the same cycle: the hit wins; y is not decremented.

## Configuration
- `BULLET_HIT_COUNT_EN` defined:
  - adds `o_hit_count` (8 bit), incremented on each accepted hit;
  - saturates at 255; reset to 0.
- `BULLET_HIT_COUNT_EN` undefined:
  - port and register are absent;
  - all other behaviour is identical.

## Structure
- Shared package `invaders_pkg`:
  - `BULLET_X_W`=5 and `BULLET_Y_W`=4;
  - the `bullet_state_t` enum (IDLE, FLYING, RETIRE);
  - the `PARK_Y` default value.
- One sub-module, `bullet_step_timer`:
  - parameter `DIV`;
  - inputs: clock, reset, synchronous clear, enable;
  - output: 1-cycle `o_tick`;
  - 32-bit counter.

## Test plan
All scenarios use `STEP_DIV`=4 and `START_Y`=14.
- Reset, then idle for 10 cycles → x=0, y=15, `o_active`=0, `o_hit_count`=0 throughout.
- `i_cannon_x`=9, fire edge at cycle 0 → x=9, y=14, active; y=13 at cycle 4, y=0 at cycle 56; parked at cycle 60, IDLE at cycle 61.
- In flight at y=10, pulse `i_hit` one cycle → parked next cycle and `o_hit_count`=1. Fire edge 2 cycles later launches at y=14.
- `i_hit` coincident with a tick at y=5 → y stays 5 until retire; no decrement observed.
- Hold `i_fire` high for 100 cycles; also change `i_cannon_x` mid-flight → exactly one launch, x unchanged. A second press during flight is dropped.
- Assert `i_reset` at y=7 → outputs park asynchronously; after release, IDLE and a fresh fire edge launches normally.
